// File: rtl/game_pkg.sv
// game_pkg: shared move, state and result types for the rock-paper-scissors round sequencer
package game_pkg;
    typedef enum logic [1:0] {ROCK, PAPER, SCISSORS, ILLEGAL} move_t;
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_REVEAL, S_SCORE, S_MATCH_END} round_state_t;
    typedef enum logic [1:0] {P1_WIN, P2_WIN, DRAW} result_t;
    localparam int COMBO_W = 9;
endpackage

// File: rtl/rps_judge.sv
// rps_judge: combinational round verdict and 9-way move combo one-hot
module rps_judge
    import game_pkg::*;
(
    input  move_t                m1,
    input  move_t                m2,
    input  logic                 h1,
    input  logic                 h2,
    output result_t              res,
    output logic [COMBO_W-1:0]   combo
);
    logic       beats;
    logic [3:0] idx;
    assign beats = (m1 == PAPER && m2 == ROCK) || (m1 == SCISSORS && m2 == PAPER) ||
                   (m1 == ROCK && m2 == SCISSORS);
    assign idx   = 4'(m1) * 4'd3 + 4'(m2);
    // a missing move forfeits to a present one; both missing is a draw
    assign res   = (h1 && h2) ? (m1 == m2 ? DRAW : beats ? P1_WIN : P2_WIN) :
                   h1 ? P1_WIN : h2 ? P2_WIN : DRAW;
    assign combo = (h1 && h2) ? COMBO_W'(1) << idx : '0;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: collect, reveal, judge and score one rock-paper-scissors round per start.
// Optional COLLECT forfeit timeout enabled by defining ROUND_TIMEOUT_EN.
module round_sequencer
    import game_pkg::*;
#(
    parameter int WIN_SCORE      = 3,
    parameter int REVEAL_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SW            = $clog2(WIN_SCORE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_scores,
    input  logic               p1_valid,
    input  logic [1:0]         p1_move,
    input  logic               p2_valid,
    input  logic [1:0]         p2_move,
    output logic               p1_ack,
    output logic               p2_ack,
    output logic               busy,
    output logic               round_done,
    output logic [COMBO_W-1:0] combo,
    output logic [SW-1:0]      p1_score,
    output logic [SW-1:0]      p2_score,
    output logic               match_over,
    output logic               winner
);
    localparam int RW = $clog2(REVEAL_CYCLES + 1);
    round_state_t       state;
    move_t              m1, m2;
    logic               h1, h2, l1, l2;
    logic [RW-1:0]      rcnt;
    logic [SW-1:0]      s1, s2;
    result_t            res;
    logic [COMBO_W-1:0] cmb;
`ifdef ROUND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      tcnt;
`endif
    rps_judge u_judge (.m1(m1), .m2(m2), .h1(h1), .h2(h2), .res(res), .combo(cmb));
    assign l1   = p1_valid && p1_move != 2'b11 && !h1;
    assign l2   = p2_valid && p2_move != 2'b11 && !h2;
    assign s1   = p1_score + SW'(res == P1_WIN);
    assign s2   = p2_score + SW'(res == P2_WIN);
    assign busy = state != S_IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            m1         <= ROCK;
            m2         <= ROCK;
            h1         <= 1'b0;
            h2         <= 1'b0;
            rcnt       <= '0;
            p1_ack     <= 1'b0;
            p2_ack     <= 1'b0;
            round_done <= 1'b0;
            combo      <= '0;
            p1_score   <= '0;
            p2_score   <= '0;
            match_over <= 1'b0;
            winner     <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            p1_ack     <= 1'b0;
            p2_ack     <= 1'b0;
            round_done <= 1'b0;
            if (clear_scores) begin
                state      <= S_IDLE;
                h1         <= 1'b0;
                h2         <= 1'b0;
                combo      <= '0;
                p1_score   <= '0;
                p2_score   <= '0;
                match_over <= 1'b0;
                winner     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state <= S_COLLECT;
                        h1    <= 1'b0;
                        h2    <= 1'b0;
                        combo <= '0;
`ifdef ROUND_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                    S_COLLECT: begin
                        if (l1) begin
                            m1     <= move_t'(p1_move);
                            h1     <= 1'b1;
                            p1_ack <= 1'b1;
                        end
                        if (l2) begin
                            m2     <= move_t'(p2_move);
                            h2     <= 1'b1;
                            p2_ack <= 1'b1;
                        end
                        if ((h1 || l1) && (h2 || l2)) begin
                            state <= S_REVEAL;
                            rcnt  <= RW'(REVEAL_CYCLES - 1);
                        end
`ifdef ROUND_TIMEOUT_EN
                        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) state <= S_SCORE;
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                    S_REVEAL: if (rcnt == '0) state <= S_SCORE; else rcnt <= rcnt - 1'b1;
                    S_SCORE: begin
                        round_done <= 1'b1;
                        combo      <= cmb;
                        p1_score   <= s1;
                        p2_score   <= s2;
                        if (s1 == SW'(WIN_SCORE) || s2 == SW'(WIN_SCORE)) begin
                            state      <= S_MATCH_END;
                            match_over <= 1'b1;
                            winner     <= s2 == SW'(WIN_SCORE);
                        end else state <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
